// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, bus widths and the address legality check.
package rv_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Misaligned or past the end of the array; comparison is unsigned so high addresses never wrap.
  function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth_words);
  endfunction

endpackage

// File: rtl/rv_mem_array.sv
// Word-addressed single-port synchronous RAM with per-byte write enables.
// Read data is registered and only changes on an enabled read.
module rv_mem_array
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [BE_W-1:0]                be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);

  // Contents start at zero at power-up and are deliberately untouched by reset.
  logic [WORD_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < BE_W; k++) begin
          if (be[k]) begin
            mem[idx][8*k +: 8] <= wdata[8*k +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/rv_data_mem_responder.sv
// Load/store responder: one outstanding word request, programmable wait states,
// array access on the edge that enters RESP.
module rv_data_mem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("rv_data_mem_responder: LATENCY must be within 0..15");
  end

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic [BE_W-1:0]    be_q;
  logic               rsp_err_q;
  logic               rsp_load_q;

  logic               accept;
  logic               enter_resp;
  logic               acc_we;
  logic [31:0]        acc_addr;
  logic [WORD_W-1:0]  acc_wdata;
  logic [BE_W-1:0]    acc_be;
  logic               acc_err;
  logic [WORD_W-1:0]  mem_rdata;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;

  // With zero latency the array is hit on the accepting edge, so take the live request there.
  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == IDLE) ? req_be    : be_q;
  assign acc_err   = addr_error(acc_addr, DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (enter_resp) begin
        rsp_err_q  <= acc_err;
        rsp_load_q <= !acc_err && !acc_we;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_err_q  <= 1'b0;
        rsp_load_q <= 1'b0;
      end
    end
  end

  rv_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (enter_resp && !acc_err),
    .we    (acc_we),
    .be    (acc_be),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // Array read data holds between reads, so masking keeps it stable for the whole response.
  assign rsp_rdata = rsp_load_q ? mem_rdata : '0;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rv_data_mem_responder.sv
// Directed bench: table of single transactions on a LATENCY=2 responder plus
// backpressure and reset-in-WAIT sequences (the latter on a LATENCY=3 instance).
module tb_rv_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
  logic [31:0] rsp_rdata3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  rv_data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  rv_data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid3),
    .rsp_ready (rsp_ready3),
    .rsp_rdata (rsp_rdata3),
    .rsp_err   (rsp_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete transaction; lat counts cycles from the accept cycle to the first rsp_valid cycle.
  task automatic apply_stimulus(input bit on3, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rdata, output logic err, output int lat);
    int budget;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = 1'b1;
    if (on3) req_valid3 = 1'b1;
    else     req_valid  = 1'b1;
    budget = 0;
    while (((on3 ? req_ready3 : req_ready) !== 1'b1) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check_output("accept_in_time", 32'(budget < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    lat = 1;
    while (((on3 ? rsp_valid3 : rsp_valid) !== 1'b1) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = on3 ? rsp_rdata3 : rsp_rdata;
    err   = on3 ? rsp_err3 : rsp_err;
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          cyc;

    vecs.push_back('{"sw_10",       1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,          1'b0});
    vecs.push_back('{"lw_10",       1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF,  1'b0});
    vecs.push_back('{"sw_20_full",  1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,          1'b0});
    vecs.push_back('{"sw_20_be5",   1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,          1'b0});
    vecs.push_back('{"lw_20_merge", 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD,  1'b0});
    vecs.push_back('{"lw_13_misal", 1'b0, 32'h0000_0013, 32'h0,         4'hF, 32'h0,          1'b1});
    vecs.push_back('{"sw_400_oor",  1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 32'h0,          1'b1});
    vecs.push_back('{"lw_0_clean",  1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,          1'b0});
    vecs.push_back('{"sw_20_be0",   1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0,          1'b0});
    vecs.push_back('{"lw_20_kept",  1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD,  1'b0});
    vecs.push_back('{"sw_12_misal", 1'b1, 32'h0000_0012, 32'h5555_5555, 4'hF, 32'h0,          1'b1});
    vecs.push_back('{"lw_10_kept",  1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF,  1'b0});
    vecs.push_back('{"sw_3fc_b3",   1'b1, 32'h0000_03FC, 32'h1234_5678, 4'h8, 32'h0,          1'b0});
    vecs.push_back('{"lw_3fc_last", 1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h1200_0000,  1'b0});
    vecs.push_back('{"lw_top_nowr", 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,          1'b1});
    vecs.push_back('{"lw_404_oor",  1'b0, 32'h0000_0404, 32'h0,         4'h0, 32'h0,          1'b1});

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    rsp_ready  = 1'b1;
    rsp_ready3 = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_output("rst_rsp_err",   32'(rsp_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("post_rst_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      apply_stimulus(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      check_output({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check_output({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      check_output({vecs[i].name, "_lat"}, 32'(lat), 32'd3);
    end

    // Backpressure: response held for 5 cycles while a second request waits with a changing address.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_be    = 4'h0;
    rsp_ready = 1'b0;
    check_output("bp_idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h20;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_output("bp_lat", 32'(cyc), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check_output("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check_output("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("bp_after_hs_ready", 32'(req_ready), 32'd1);
    check_output("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_output("bp_second_lat",   32'(cyc), 32'd3);
    check_output("bp_second_rdata", rsp_rdata, 32'h11BB_33DD);
    check_output("bp_second_err",   32'(rsp_err), 32'd0);
    @(posedge clk);

    // Reset while the LATENCY=3 instance is in WAIT on a store: the store must be dropped.
    @(negedge clk);
    req_we     = 1'b1;
    req_addr   = 32'h8;
    req_wdata  = 32'h55;
    req_be     = 4'hF;
    req_valid3 = 1'b1;
    check_output("rw_idle_ready", 32'(req_ready3), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid3 = 1'b0;
    check_output("rw_in_wait_ready", 32'(req_ready3), 32'd0);
    check_output("rw_in_wait_valid", 32'(rsp_valid3), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_output("rw_rst_ready", 32'(req_ready3), 32'd1);
    check_output("rw_rst_valid", 32'(rsp_valid3), 32'd0);
    reset = 1'b0;
    apply_stimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    check_output("rw_lw8_rdata", rd, 32'h0);
    check_output("rw_lw8_err",   32'(er), 32'd0);
    check_output("rw_lw8_lat",   32'(lat), 32'd4);
    apply_stimulus(1'b1, 1'b1, 32'h8, 32'h55, 4'hF, rd, er, lat);
    apply_stimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    check_output("l3_lw8_rdata", rd, 32'h55);
    check_output("l3_lw8_lat",   32'(lat), 32'd4);

    // The array survives reset on the other instance too.
    apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_output("post_rst_lw10", rd, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
